// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the 6-byte time frame (FF A5 HH MM SS F0).
// The transmit sequencer and the receive decoder both build on these.
//   FRAME_HEAD0/1, FRAME_TAIL : fixed framing bytes
//   FRAME_LEN, FRAME_LAST_IDX : frame length and index of its last byte
//   tx_state_e                : transmit sequencer state encoding
//   cnt_width()               : counter width for a cycle-count parameter
// -----------------------------------------------------------------------------
package uart_frame_pkg;

    localparam logic [7:0]  FRAME_HEAD0    = 8'hFF;
    localparam logic [7:0]  FRAME_HEAD1    = 8'hA5;
    localparam logic [7:0]  FRAME_TAIL     = 8'hF0;
    localparam int unsigned FRAME_LEN      = 6;
    localparam logic [2:0]  FRAME_LAST_IDX = 3'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_e;

    // $clog2 of the cycle count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/time_frame_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// time_frame_tx_ctrl_if
// Signals between the frame sequencer, the clock generator and the UART
// byte transmitter.
//   master : the sequencer (consumes request/time/tx_done, drives the rest)
//   slave  : its environment (clock generator + transmitter)
// -----------------------------------------------------------------------------
interface time_frame_tx_ctrl_if;

    logic       send_req;     // one-cycle request to send the current time
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Seconds;
    logic       tx_done;      // transmitter finished the current byte
    logic [7:0] tx_data;      // byte for the transmitter
    logic       send_en;      // one-cycle start pulse for the transmitter
    logic       busy;         // frame in progress
    logic       frame_done;   // one-cycle pulse after the last byte
    logic       tx_error;     // one-cycle pulse on watchdog abort
    logic       req_dropped;  // one-cycle pulse when a request is discarded

    modport master (
        input  send_req, Hour, Minute, Seconds, tx_done,
        output tx_data, send_en, busy, frame_done, tx_error, req_dropped
    );

    modport slave (
        output send_req, Hour, Minute, Seconds, tx_done,
        input  tx_data, send_en, busy, frame_done, tx_error, req_dropped
    );

endinterface

// File: rtl/time_frame_tx_ctrl_byte_sel.sv
// -----------------------------------------------------------------------------
// frame_byte_sel
// Combinational frame-index to byte mux.
//   idx_i                      : byte index 0..5
//   hour_i/minute_i/seconds_i  : snapshot registers
//   byte_o                     : frame byte at idx_i
// -----------------------------------------------------------------------------
module frame_byte_sel
    import uart_frame_pkg::*;
(
    input  logic [2:0] idx_i,
    input  logic [7:0] hour_i,
    input  logic [7:0] minute_i,
    input  logic [7:0] seconds_i,
    output logic [7:0] byte_o
);

    always_comb begin
        case (idx_i)
            3'd0:    byte_o = FRAME_HEAD0;
            3'd1:    byte_o = FRAME_HEAD1;
            3'd2:    byte_o = hour_i;
            3'd3:    byte_o = minute_i;
            3'd4:    byte_o = seconds_i;
            default: byte_o = FRAME_TAIL;
        endcase
    end

endmodule

// File: rtl/time_frame_tx_ctrl.sv
// -----------------------------------------------------------------------------
// time_frame_tx_ctrl
// Turns each time-update request into a 6-byte UART frame, handing bytes to
// the transmitter one at a time with a send_en/tx_done handshake. Queues at
// most one request that arrives while a frame is in flight.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : time_frame_tx_ctrl_if.master (request, time, tx handshake,
//                status pulses)
// Parameters
//   GAP_CYCLES  : idle cycles between tx_done and the next send_en
//   WDOG_CYCLES : cycles allowed per byte (counted from send_en) before abort
// -----------------------------------------------------------------------------
module time_frame_tx_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned WDOG_CYCLES = 1_000_000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    time_frame_tx_ctrl_if.master bus
);

    localparam int unsigned GAP_W  = cnt_width(GAP_CYCLES);
    localparam int unsigned WDOG_W = cnt_width(WDOG_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

    tx_state_e         state_q;
    logic [2:0]        idx_q, idx_d;
    logic              pending_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [WDOG_W-1:0] wdog_cnt_q;
    logic [7:0]        hour_q, minute_q, seconds_q;
    logic [7:0]        tx_data_q;
    logic              send_en_q, busy_q, frame_done_q, tx_error_q, req_dropped_q;
    logic [7:0]        sel_byte;

    // Index for the byte about to be launched: reset in LOAD, advanced on an
    // accepted tx_done, held at the last byte.
    always_comb begin
        idx_d = idx_q;
        if (state_q == ST_LOAD) begin
            idx_d = 3'd0;
        end else if (state_q == ST_WAIT && bus.tx_done && idx_q != FRAME_LAST_IDX) begin
            idx_d = idx_q + 3'd1;
        end
    end

    frame_byte_sel u_byte_sel (
        .idx_i     (idx_d),
        .hour_i    (hour_q),
        .minute_i  (minute_q),
        .seconds_i (seconds_q),
        .byte_o    (sel_byte)
    );

    // NOTE: several branches below assign the same register in one cycle; the
    // last non-blocking assignment in program order is the one that lands, so
    // state-specific overrides are written after the generic request handling.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            gap_cnt_q     <= '0;
            wdog_cnt_q    <= '0;
            hour_q        <= '0;
            minute_q      <= '0;
            seconds_q     <= '0;
            tx_data_q     <= '0;
            send_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            tx_error_q    <= 1'b0;
            req_dropped_q <= 1'b0;
        end else begin
            send_en_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            tx_error_q    <= 1'b0;
            req_dropped_q <= 1'b0;
            idx_q         <= idx_d;

            // A request during a frame is remembered once; a further one is lost.
            if (bus.send_req && state_q != ST_IDLE) begin
                if (pending_q) req_dropped_q <= 1'b1;
                else           pending_q     <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.send_req) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    hour_q     <= bus.Hour;
                    minute_q   <= bus.Minute;
                    seconds_q  <= bus.Seconds;
                    state_q    <= ST_START;
                    send_en_q  <= 1'b1;
                    tx_data_q  <= sel_byte;
                    wdog_cnt_q <= '0;
                end
                ST_START: begin
                    // Watchdog runs from the send_en cycle onward.
                    state_q    <= ST_WAIT;
                    wdog_cnt_q <= wdog_cnt_q + 1'b1;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        if (idx_q == FRAME_LAST_IDX) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_q    <= ST_START;
                            send_en_q  <= 1'b1;
                            tx_data_q  <= sel_byte;
                            wdog_cnt_q <= '0;
                        end else begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= '0;
                        end
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        // Abort: nothing queued survives, including a request
                        // arriving in this very cycle.
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        tx_error_q    <= 1'b1;
                        pending_q     <= 1'b0;
                        req_dropped_q <= bus.send_req;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q    <= ST_START;
                        send_en_q  <= 1'b1;
                        tx_data_q  <= sel_byte;
                        wdog_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A request landing in this cycle is treated as pending.
                    if (pending_q || bus.send_req) begin
                        state_q   <= ST_LOAD;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.send_en     = send_en_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.tx_error    = tx_error_q;
    assign bus.req_dropped = req_dropped_q;

endmodule

// File: tb/tb_time_frame_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_frame_tx_ctrl
// Two sequencers (GAP_CYCLES 0 and 3, WDOG_CYCLES 100) share one stimulus
// path selected by 'sel'. A transmitter model answers each send_en with
// tx_done after 'lat' cycles; a frame model derives the expected bytes and
// byte spacing from the frame format and the time seen during LOAD.
// -----------------------------------------------------------------------------
module tb_time_frame_tx_ctrl;

    logic       Clk;
    logic       Reset;
    logic       req, tx_done_b, sel;
    logic [7:0] hh, mm, ss;

    time_frame_tx_ctrl_if if0 ();
    time_frame_tx_ctrl_if if3 ();

    assign if0.send_req = req & ~sel;
    assign if3.send_req = req & sel;
    assign if0.tx_done  = tx_done_b & ~sel;
    assign if3.tx_done  = tx_done_b & sel;
    assign if0.Hour = hh;  assign if0.Minute = mm;  assign if0.Seconds = ss;
    assign if3.Hour = hh;  assign if3.Minute = mm;  assign if3.Seconds = ss;

    time_frame_tx_ctrl #(.GAP_CYCLES(0), .WDOG_CYCLES(100)) dut0 (.Clk(Clk), .Reset(Reset), .bus(if0));
    time_frame_tx_ctrl #(.GAP_CYCLES(3), .WDOG_CYCLES(100)) dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));

    logic [7:0] o_data;
    logic       o_send_en, o_busy, o_frame_done, o_tx_error, o_req_dropped;
    assign o_data        = sel ? if3.tx_data     : if0.tx_data;
    assign o_send_en     = sel ? if3.send_en     : if0.send_en;
    assign o_busy        = sel ? if3.busy        : if0.busy;
    assign o_frame_done  = sel ? if3.frame_done  : if0.frame_done;
    assign o_tx_error    = sel ? if3.tx_error    : if0.tx_error;
    assign o_req_dropped = sel ? if3.req_dropped : if0.req_dropped;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         vectors = 0, miscompares = 0;
    int         cyc = 0;
    int         lat = 10, withhold_idx = -1;
    int         done_at = -1, last_done = 0, last_send_cyc = 0, pos = 0;
    bit         done_live = 1'b0, rst_prev = 1'b0;
    int         send_en_cnt = 0, frame_done_cnt = 0, drop_cnt = 0;
    logic [7:0] exp_frame [6];
    logic [7:0] cur_byte;
    logic [7:0] hh_prev, mm_prev, ss_prev;
    logic [7:0] frame_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: advance, sample outputs, run the transmitter and frame models.
    task automatic tick();
        int gap_now;
        hh_prev = hh; mm_prev = mm; ss_prev = ss; rst_prev = Reset;
        @(posedge Clk); #1;
        cyc++;
        req = 1'b0; tx_done_b = 1'b0;
        gap_now = sel ? 3 : 0;
        if (rst_prev) begin pos = 0; done_live = 1'b0; end
        if (o_req_dropped) drop_cnt++;
        if (o_tx_error) pos = 0;
        if (o_send_en) begin
            send_en_cnt++;
            last_send_cyc = cyc;
            if (pos == 0) begin
                // Time is captured in the LOAD cycle, one before the first send_en.
                exp_frame = '{8'hFF, 8'hA5, hh_prev, mm_prev, ss_prev, 8'hF0};
                frame_q.delete();
            end else begin
                check("byte_spacing", cyc, last_done + 1 + gap_now);
            end
            if (pos < 6) check("byte_value", {24'd0, o_data}, {24'd0, exp_frame[pos]});
            else         check("extra_send_en", pos, 5);
            frame_q.push_back(o_data);
            cur_byte  = o_data;
            done_live = (pos != withhold_idx);
            done_at   = done_live ? cyc + lat : -1;
            pos++;
        end
        if (done_at >= 0 && cyc == done_at) begin
            if (done_live) check("data_stable", {24'd0, o_data}, {24'd0, cur_byte});
            tx_done_b = 1'b1;
            last_done = cyc;
            done_at   = -1;
            done_live = 1'b0;
        end
        if (o_frame_done) begin
            frame_done_cnt++;
            check("frame_done_bytes", pos, 6);
            check("frame_done_latency", cyc, last_done + 1);
            pos = 0;
        end
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!o_frame_done && n < budget);
        if (!o_frame_done) check("frame_done_timeout", o_frame_done, 1);
    endtask

    task automatic wait_pos(input int p, input int budget);
        int n = 0;
        while (pos != p && n < budget) begin tick(); n++; end
        if (pos != p) check("send_en_timeout", pos, p);
    endtask

    initial begin : main
        logic [7:0] ref_frame [6];
        int se0, fd0, drop0, win, s_cyc, n;

        Reset = 1'b1; req = 1'b0; tx_done_b = 1'b0; sel = 1'b0;
        hh = '0; mm = '0; ss = '0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        check("reset_outputs_gap0", {19'd0, if0.tx_data, if0.send_en, if0.busy, if0.frame_done, if0.tx_error, if0.req_dropped}, 0);
        check("reset_outputs_gap3", {19'd0, if3.tx_data, if3.send_en, if3.busy, if3.frame_done, if3.tx_error, if3.req_dropped}, 0);

        // tx_done while idle must not launch anything.
        win = 0;
        for (int i = 0; i < 10; i++) begin
            tx_done_b = (i == 0) || (i < 8 && $urandom_range(0, 1) != 0);
            tick();
            win += int'(o_send_en);
        end
        check("idle_tx_done_send_en", win, 0);
        check("idle_tx_done_busy", o_busy, 0);

        // Single frame, no gap.
        sel = 1'b0; lat = 10; hh = 8'd12; mm = 8'd34; ss = 8'd56;
        se0 = send_en_cnt; fd0 = frame_done_cnt;
        req = 1'b1;
        tick();
        check("busy_at_load", o_busy, 1);
        tick();
        check("first_send_en", o_send_en, 1);
        check("first_byte", {24'd0, o_data}, 32'hFF);
        wait_frame(200);
        ref_frame = '{8'hFF, 8'hA5, 8'h0C, 8'h22, 8'h38, 8'hF0};
        check("single_len", frame_q.size(), 6);
        for (int i = 0; i < 6; i++) check("single_byte", {24'd0, frame_q[i]}, {24'd0, ref_frame[i]});
        check("single_send_en_count", send_en_cnt - se0, 6);
        check("single_frame_done_count", frame_done_cnt - fd0, 1);
        check("busy_at_frame_done", o_busy, 1);
        tick();
        check("busy_after_frame", o_busy, 0);

        // Gap of 3 cycles, then randomized frames on both instances.
        sel = 1'b1; hh = 8'($urandom_range(0, 23)); mm = 8'($urandom_range(0, 59)); ss = 8'($urandom_range(0, 59));
        req = 1'b1;
        tick();
        wait_frame(300);
        check("gap_len", frame_q.size(), 6);
        tick();
        for (int k = 0; k < 6; k++) begin
            sel = k[0];
            lat = $urandom_range(1, 12);
            hh = 8'($urandom_range(0, 23)); mm = 8'($urandom_range(0, 59)); ss = 8'($urandom_range(0, 59));
            req = 1'b1;
            tick();
            wait_frame(400);
            check("rand_len", frame_q.size(), 6);
            tick();
        end

        // Queueing: one pending request, one dropped, time re-sampled at LOAD.
        sel = 1'b0; lat = 10; hh = 8'd12; mm = 8'd34; ss = 8'd56;
        drop0 = drop_cnt;
        req = 1'b1;
        tick();
        wait_pos(3, 100);
        tick();
        req = 1'b1;
        tick();
        ss = 8'd57;
        tick();
        req = 1'b1;
        tick();
        check("third_req_dropped", o_req_dropped, 1);
        wait_frame(200);
        tick();
        check("pending_busy_held", o_busy, 1);
        check("pending_no_early_send", o_send_en, 0);
        tick();
        check("pending_send_en", o_send_en, 1);
        check("pending_first_byte", {24'd0, o_data}, 32'hFF);
        wait_frame(200);
        check("pending_seconds", {24'd0, frame_q[4]}, 32'h39);
        check("drop_count", drop_cnt - drop0, 1);
        tick();
        check("queue_idle", o_busy, 0);

        // Watchdog: byte 3 never completes.
        sel = 1'b0; withhold_idx = 3;
        req = 1'b1;
        tick();
        wait_pos(4, 100);
        s_cyc = last_send_cyc;
        n = 0;
        while (!o_tx_error && n < 150) begin tick(); n++; end
        check("wdog_latency", cyc - s_cyc, 100);
        check("wdog_busy", o_busy, 0);
        withhold_idx = -1;
        tick();
        req = 1'b1;
        tick();
        wait_frame(200);
        check("after_wdog_len", frame_q.size(), 6);
        tick();

        // Watchdog abort coinciding with a request: the request is dropped.
        sel = 1'b1; withhold_idx = 3;
        req = 1'b1;
        tick();
        wait_pos(4, 200);
        s_cyc = last_send_cyc;
        while (cyc < s_cyc + 99) tick();
        req = 1'b1;
        tick();
        check("abort_tx_error", o_tx_error, 1);
        check("abort_req_dropped", o_req_dropped, 1);
        check("abort_busy", o_busy, 0);
        withhold_idx = -1;
        win = 0;
        for (int i = 0; i < 6; i++) begin tick(); win += int'(o_send_en); end
        check("abort_no_restart", win, 0);

        // Reset during byte 4's WAIT; the late tx_done must be ignored.
        sel = 1'b0; lat = 10;
        req = 1'b1;
        tick();
        wait_pos(5, 100);
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midreset_outputs", {19'd0, o_data, o_send_en, o_busy, o_frame_done, o_tx_error, o_req_dropped}, 0);
        win = 0;
        for (int i = 0; i < 12; i++) begin tick(); win += int'(o_send_en) + int'(o_busy); end
        check("midreset_late_done_ignored", win, 0);
        req = 1'b1;
        tick();
        tick();
        check("restart_send_en", o_send_en, 1);
        check("restart_first_byte", {24'd0, o_data}, 32'hFF);
        wait_frame(200);
        check("restart_len", frame_q.size(), 6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
